// File: rtl/sw_pkg.sv
// Shared types and helpers for the stopwatch time base: lap state, BCD pair, digit increment.
package sw_pkg;

    typedef enum logic {LAP_LIVE, LAP_FROZEN} lap_state_t;

    typedef logic [7:0] bcd2_t;

    // Returns {carry, next}; >= keeps a corrupted digit from running past its limit.
    function automatic logic [4:0] bcd_inc_mod(input logic [3:0] digit, input logic [3:0] limit);
        logic c;
        c = (digit >= limit);
        return {c, c ? 4'd0 : digit + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit: increments on inc, wraps at limit, and raises carry in the cycle it wraps.
module bcd_digit_counter
    import sw_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic [3:0] value,
    output logic       carry
);

    logic [4:0] nxt;

    assign nxt   = bcd_inc_mod(value, limit);
    assign carry = inc & nxt[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   value <= '0;
        else if (clr) value <= '0;
        else if (inc) value <= nxt[3:0];
    end

endmodule

// File: rtl/stopwatch_timebase_ctrl.sv
// 1 s prescaler, cascaded BCD MM:SS counter and LIVE/FROZEN lap display selection.
module stopwatch_timebase_ctrl
    import sw_pkg::*;
#(
    parameter int          TICK_DIV = 100_000_000,
    parameter logic [7:0]  MAX_MIN  = 8'h99
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sync_reset,
    input  logic       en,
    input  logic       lap,
    output logic       sec_tick,
    output logic       wrap,
    output bcd2_t      live_min_bcd,
    output bcd2_t      live_sec_bcd,
    output bcd2_t      disp_min_bcd,
    output bcd2_t      disp_sec_bcd,
    output logic       lap_frozen
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]   pcnt;
    logic            tick, at_max, roll, clr;
    logic [3:0][3:0] dig;
    logic [4:0]      cy;
    logic            sec_tick_q, wrap_q;
    lap_state_t      state_q, state_d;
    logic            capture;
    bcd2_t           snap_min, snap_sec;

    // en is sampled: a tick only happens if en is still high on the terminal count.
    assign tick = en && (pcnt == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          pcnt <= '0;
        else if (sync_reset) pcnt <= '0;
        else if (tick)       pcnt <= '0;
        else if (en)         pcnt <= pcnt + 1'b1;
    end

    assign at_max = ({dig[3], dig[2]} == MAX_MIN) && ({dig[1], dig[0]} == 8'h59);
    // Carry out of the minute tens covers MAX_MIN=99; at_max covers smaller limits.
    assign roll   = cy[4] | (tick & at_max);
    assign clr    = sync_reset | roll;
    assign cy[0]  = tick;

    // Digits 0..3: sec ones, sec tens, min ones, min tens; carries ripple upward.
    for (genvar g = 0; g < 4; g++) begin : g_dig
        bcd_digit_counter u_dig (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (cy[g]),
            .clr   (clr),
            .limit ((g == 1) ? 4'd5 : 4'd9),
            .value (dig[g]),
            .carry (cy[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_tick_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else if (sync_reset) begin
            sec_tick_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            sec_tick_q <= tick;
            wrap_q     <= roll;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            LAP_LIVE: begin
                if (lap && en) begin
                    state_d = LAP_FROZEN;
                    capture = 1'b1;
                end
            end
            LAP_FROZEN: begin
                if (lap) state_d = LAP_LIVE;
            end
            default: state_d = LAP_LIVE;
        endcase
    end

    // Snapshot takes the pre-increment count when lap and tick coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LAP_LIVE;
            snap_min <= '0;
            snap_sec <= '0;
        end else if (sync_reset) begin
            state_q  <= LAP_LIVE;
            snap_min <= '0;
            snap_sec <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                snap_min <= {dig[3], dig[2]};
                snap_sec <= {dig[1], dig[0]};
            end
        end
    end

    assign sec_tick     = sec_tick_q;
    assign wrap         = wrap_q;
    assign live_min_bcd = {dig[3], dig[2]};
    assign live_sec_bcd = {dig[1], dig[0]};
    assign lap_frozen   = (state_q == LAP_FROZEN);
    assign disp_min_bcd = lap_frozen ? snap_min : live_min_bcd;
    assign disp_sec_bcd = lap_frozen ? snap_sec : live_sec_bcd;

endmodule

// File: tb/tb_stopwatch_timebase_ctrl.sv
// Directed vector table plus model-checked sequences for the stopwatch time base.
module tb_stopwatch_timebase_ctrl;
    import sw_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  sync_reset = 1'b0, en = 1'b0, lap = 1'b0;
    logic  sec_tick, wrap, lap_frozen;
    bcd2_t live_min_bcd, live_sec_bcd, disp_min_bcd, disp_sec_bcd;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stopwatch_timebase_ctrl #(.TICK_DIV(4), .MAX_MIN(8'h99)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_reset   (sync_reset),
        .en           (en),
        .lap          (lap),
        .sec_tick     (sec_tick),
        .wrap         (wrap),
        .live_min_bcd (live_min_bcd),
        .live_sec_bcd (live_sec_bcd),
        .disp_min_bcd (disp_min_bcd),
        .disp_sec_bcd (disp_sec_bcd),
        .lap_frozen   (lap_frozen)
    );

    typedef struct {
        logic        sr, en, lap;
        logic        tk, wr, fz;
        logic [15:0] live, disp;
    } vec_t;

    vec_t vecs[16];

    // Reference model state: prescaler, total seconds, lap state and snapshot.
    int mpc, mtot, msnap;
    bit mtk, mwr, mfz, wrap_seen;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int s);
        int m, ss;
        m  = s / 60;
        ss = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic logic [63:0] dut_word();
        return {29'd0, sec_tick, wrap, lap_frozen, live_min_bcd, live_sec_bcd,
                disp_min_bcd, disp_sec_bcd};
    endfunction

    task automatic cyc(input logic sr, input logic e, input logic l);
        bit t;
        sync_reset = sr; en = e; lap = l;
        @(posedge clk); #1;
        if (sr) begin
            mpc = 0; mtot = 0; msnap = 0; mtk = 0; mwr = 0; mfz = 0;
        end else begin
            t = e && (mpc == 3);
            if (!mfz && l && e) begin
                mfz = 1; msnap = mtot;
            end else if (mfz && l) begin
                mfz = 0;
            end
            mtk = t;
            mwr = t && (mtot == 5999);
            if (e) mpc = t ? 0 : mpc + 1;
            if (t) mtot = (mtot + 1) % 6000;
        end
        if (mwr) wrap_seen = 1;
        check("cyc", dut_word(),
              {29'd0, mtk, mwr, mfz, to_bcd(mtot), to_bcd(mfz ? msnap : mtot)});
    endtask

    initial begin
        // sr en lap | tk wr fz | live disp
        vecs[0]  = '{0,1,0, 0,0,0, 16'h0000, 16'h0000};
        vecs[1]  = '{0,1,0, 0,0,0, 16'h0000, 16'h0000};
        vecs[2]  = '{0,1,0, 0,0,0, 16'h0000, 16'h0000};
        vecs[3]  = '{0,1,0, 1,0,0, 16'h0001, 16'h0001};
        vecs[4]  = '{0,1,1, 0,0,1, 16'h0001, 16'h0001};
        vecs[5]  = '{0,1,0, 0,0,1, 16'h0001, 16'h0001};
        vecs[6]  = '{0,1,0, 0,0,1, 16'h0001, 16'h0001};
        vecs[7]  = '{0,1,0, 1,0,1, 16'h0002, 16'h0001};
        vecs[8]  = '{0,0,1, 0,0,0, 16'h0002, 16'h0002};
        vecs[9]  = '{0,0,1, 0,0,0, 16'h0002, 16'h0002};
        vecs[10] = '{0,1,0, 0,0,0, 16'h0002, 16'h0002};
        vecs[11] = '{0,1,0, 0,0,0, 16'h0002, 16'h0002};
        vecs[12] = '{0,1,0, 0,0,0, 16'h0002, 16'h0002};
        vecs[13] = '{0,1,1, 1,0,1, 16'h0003, 16'h0002};
        vecs[14] = '{1,1,1, 0,0,0, 16'h0000, 16'h0000};
        vecs[15] = '{0,0,0, 0,0,0, 16'h0000, 16'h0000};

        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_word(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", dut_word(), 64'd0);

        foreach (vecs[i]) begin
            sync_reset = vecs[i].sr; en = vecs[i].en; lap = vecs[i].lap;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), dut_word(),
                  {29'd0, vecs[i].tk, vecs[i].wr, vecs[i].fz, vecs[i].live, vecs[i].disp});
        end

        // Free run: tick every 4 cycles, 00:10 after 40 cycles.
        wrap_seen = 0;
        cyc(1, 0, 0);
        repeat (40) cyc(0, 1, 0);
        check("run40_live", {live_min_bcd, live_sec_bcd}, 16'h0010);
        check("run40_wrap", 64'(wrap_seen), 64'd0);

        // Pause keeps the sub-second phase.
        cyc(1, 0, 0);
        repeat (2) cyc(0, 1, 0);
        repeat (10) cyc(0, 0, 0);
        cyc(0, 1, 0);
        check("resume_1st", 64'(sec_tick), 64'd0);
        cyc(0, 1, 0);
        check("resume_2nd", 64'(sec_tick), 64'd1);

        // Carries and wrap.
        cyc(1, 0, 0);
        wrap_seen = 0;
        repeat (59 * 4) cyc(0, 1, 0);
        check("at_0059", {live_min_bcd, live_sec_bcd}, 16'h0059);
        repeat (4) cyc(0, 1, 0);
        check("at_0100", {live_min_bcd, live_sec_bcd}, 16'h0100);
        for (int g = 0; g < 30000 && !(mtot == 5999 && mpc == 0); g++) cyc(0, 1, 0);
        check("at_9959", {live_min_bcd, live_sec_bcd}, 16'h9959);
        check("no_early_wrap", 64'(wrap_seen), 64'd0);
        repeat (4) cyc(0, 1, 0);
        check("wrap_0000", {wrap, live_min_bcd, live_sec_bcd}, {1'b1, 16'h0000});
        cyc(0, 1, 0);
        check("wrap_1cyc", 64'(wrap), 64'd0);

        // Lap freeze and release.
        cyc(1, 0, 0);
        repeat (20) cyc(0, 1, 0);
        cyc(0, 1, 1);
        check("lap_freeze", {lap_frozen, disp_min_bcd, disp_sec_bcd}, {1'b1, 16'h0005});
        repeat (11) cyc(0, 1, 0);
        check("frozen_live", {live_min_bcd, live_sec_bcd, disp_min_bcd, disp_sec_bcd},
              {16'h0008, 16'h0005});
        cyc(0, 1, 1);
        check("lap_release", {lap_frozen, disp_min_bcd, disp_sec_bcd}, {1'b0, 16'h0008});

        // Lap coincident with 00:09 -> 00:10.
        for (int g = 0; g < 100 && !(mtot == 9 && mpc == 3); g++) cyc(0, 1, 0);
        cyc(0, 1, 1);
        check("lap_tick", {sec_tick, lap_frozen, live_min_bcd, live_sec_bcd,
              disp_min_bcd, disp_sec_bcd}, {2'b11, 16'h0010, 16'h0009});
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        check("lap_en0_live", 64'(lap_frozen), 64'd0);

        // sync_reset while frozen and mid-prescale.
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        cyc(1, 1, 0);
        check("sreset_all0", dut_word(), 64'd0);
        repeat (3) cyc(0, 1, 0);
        check("sreset_3", 64'(sec_tick), 64'd0);
        cyc(0, 1, 0);
        check("sreset_4", 64'(sec_tick), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
